// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC owner, single-outstanding imem fetch, output register
//
// Purpose
//   Owns the architectural PC and issues one instruction-memory request at a
//   time. The returned word is held in an output register with a valid/ready
//   handshake toward decode. Branch/jump redirects retarget the PC and squash
//   any fetch that is still in flight.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   imem_req_valid/ready/addr        fetch request (addr = pc)
//   imem_resp_valid/data/err         fetch response, one per accepted request
//   redirect_valid/redirect_pc       taken branch/jump, one-cycle pulse
//   inst_valid/inst_ready            output handshake toward decode
//   inst, inst_pc                    held instruction word and its PC
//   inst_opcode/funct3/funct7        slices of inst
//   fetch_fault                      sticky fault flag (access fault or misaligned redirect)
//
// Optional feature (macro FETCH_PERF_CNT_EN)
//   Adds perf_fetched / perf_squashed 64-bit saturating counters.

module instr_fetch_unit #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            imem_resp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      inst_opcode,
    output logic [2:0]      inst_funct3,
    output logic [6:0]      inst_funct7,
    output logic            fetch_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [63:0]     perf_fetched,
    output logic [63:0]     perf_squashed
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic            drop, drop_next;
    logic            inst_valid_next;
    logic            fault_next;
    logic            inst_load;
    logic            req_fire;

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign inst_opcode = inst[6:0];
    assign inst_funct3 = inst[14:12];
    assign inst_funct7 = inst[31:25];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            inst_valid  <= 1'b0;
            fetch_fault <= 1'b0;
            inst        <= NOP;
            inst_pc     <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            drop        <= drop_next;
            inst_valid  <= inst_valid_next;
            fetch_fault <= fault_next;
            if (inst_load) begin
                inst    <= imem_resp_data;
                inst_pc <= pc;
            end
        end
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        drop_next       = drop;
        inst_valid_next = inst_valid;
        fault_next      = fetch_fault;
        inst_load       = 1'b0;

        case (state)
            S_REQ: begin
                if (imem_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (drop) begin
                        drop_next  = 1'b0;
                        state_next = S_REQ;
                    end else if (imem_resp_err) begin
                        fault_next = 1'b1;
                        state_next = S_FAULT;
                    end else begin
                        inst_load       = 1'b1;
                        inst_valid_next = 1'b1;
                        state_next      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    inst_valid_next = 1'b0;
                    pc_next         = pc + XLEN'(4);
                    state_next      = S_REQ;
                end
            end
            S_FAULT: begin
                // A fetch squashed by a misaligned redirect may still answer here.
                if (imem_resp_valid && drop) begin
                    drop_next = 1'b0;
                end
            end
            default: state_next = S_REQ;
        endcase

        // Redirect overrides everything above. Any request still outstanding
        // after this edge belongs to the old path and must be dropped.
        if (redirect_valid) begin
            pc_next         = redirect_pc;
            inst_load       = 1'b0;
            inst_valid_next = 1'b0;
            drop_next       = req_fire || (((state == S_WAIT) || drop) && !imem_resp_valid);
            if (redirect_pc[1:0] != 2'b00) begin
                fault_next = 1'b1;
                state_next = S_FAULT;
            end else begin
                fault_next = 1'b0;
                // A stale fetch still pending (including one left over from a
                // misaligned redirect out of FAULT) is absorbed in WAIT before
                // the new path issues, keeping at most one request outstanding.
                state_next = drop_next ? S_WAIT : S_REQ;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic count_fetch;
    logic count_squash;

    assign count_fetch  = inst_valid && inst_ready && !redirect_valid;
    assign count_squash = (redirect_valid && (state == S_HOLD)) ||
                          (imem_resp_valid && (drop || (redirect_valid && (state == S_WAIT))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched  <= '0;
            perf_squashed <= '0;
        end else begin
            if (count_fetch && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 64'd1;
            end
            if (count_squash && (perf_squashed != '1)) begin
                perf_squashed <= perf_squashed + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized bench for instr_fetch_unit against a transaction-level fetch model

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic [6:0]  inst_opcode;
    logic [2:0]  inst_funct3;
    logic [6:0]  inst_funct7;
    logic        fetch_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [63:0] perf_fetched;
    logic [63:0] perf_squashed;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .imem_resp_err  (imem_resp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_opcode    (inst_opcode),
        .inst_funct3    (inst_funct3),
        .inst_funct7    (inst_funct7),
        .fetch_fault    (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_squashed  (perf_squashed)
`endif
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_valid = -1;

    // Memory side: requests in flight, served in order.
    logic [63:0] q_addr[$];
    logic        q_stale[$];
    int          q_due[$];

    // Architectural model: the PC the fetch unit should be on, and the fault flag.
    logic [63:0] exp_pc;
    logic        exp_fault;

    int          p_ready, p_iready, p_redir, p_err, max_lat;
    logic        frc_valid;
    logic [63:0] frc_pc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0] * 32'd2654435761;
        return lo ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    // Called at a negedge: check outputs, drive this cycle's inputs, advance model.
    task automatic step();
        logic [31:0] w;
        logic [63:0] a;
        logic        stale;
        logic        do_redir;
        logic [63:0] tgt;
        int          r;

        chk("fault", fetch_fault, exp_fault);
        if (exp_fault) begin
            chk("req_in_fault", imem_req_valid, 1'b0);
            chk("valid_in_fault", inst_valid, 1'b0);
        end
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
        if (inst_valid) begin
            w = mem_word(exp_pc);
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", inst, w);
            chk("opcode", inst_opcode, w[6:0]);
            chk("funct3", inst_funct3, w[14:12]);
            chk("funct7", inst_funct7, w[31:25]);
            if (first_valid < 0) first_valid = cyc;
        end

        imem_req_ready  = ($urandom_range(99) < p_ready);
        inst_ready      = ($urandom_range(99) < p_iready);
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        imem_resp_err   = 1'($urandom_range(1));
        stale           = 1'b0;
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
            a     = q_addr.pop_front();
            stale = q_stale.pop_front();
            void'(q_due.pop_front());
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(a);
            imem_resp_err   = ($urandom_range(99) < p_err);
        end

        tgt      = {$urandom, $urandom};
        do_redir = frc_valid || ($urandom_range(99) < p_redir);
        if (frc_valid) begin
            tgt = frc_pc;
        end else if (do_redir) begin
            r = $urandom_range(9);
            if (r == 0)      tgt = 64'hFFFF_FFFF_FFFF_FFF8;
            else if (r == 1) tgt = 64'h8000_0000 + 64'($urandom_range(63) * 4 + $urandom_range(3, 1));
            else             tgt = 64'h8000_0000 + 64'($urandom_range(1023) * 4);
        end
        frc_valid      = 1'b0;
        redirect_valid = do_redir;
        redirect_pc    = tgt;

        if (imem_resp_valid && !stale && !do_redir && imem_resp_err) exp_fault = 1'b1;
        if (do_redir) begin
            for (int i = 0; i < q_stale.size(); i++) q_stale[i] = 1'b1;
            exp_pc    = tgt;
            exp_fault = (tgt[1:0] != 2'b00);
        end else if (inst_valid && inst_ready) begin
            exp_pc = exp_pc + 64'd4;
        end
        if (imem_req_valid && imem_req_ready) begin
            q_addr.push_back(imem_req_addr);
            q_stale.push_back(do_redir);
            q_due.push_back(cyc + 1 + $urandom_range(max_lat - 1));
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            @(negedge clk);
        end
    endtask

    task automatic quiet();
        p_ready = 100; p_iready = 100; p_redir = 0; p_err = 0; max_lat = 1;
    endtask

    initial begin
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        inst_ready      = 1'b0;
        frc_valid       = 1'b0;
        frc_pc          = '0;
        exp_pc          = 64'h0000_0000_8000_0000;
        exp_fault       = 1'b0;
        quiet();

        repeat (3) @(negedge clk);
        chk("rst_req_valid", imem_req_valid, 1'b1);
        chk("rst_req_addr", imem_req_addr, 64'h0000_0000_8000_0000);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_inst_pc", inst_pc, 64'h0);
        chk("rst_fault", fetch_fault, 1'b0);
        rst_n = 1'b1;

        // Ideal memory and consumer: first word visible two edges after release.
        run(12);
        chk("first_valid_cyc", 64'(first_valid), 64'd2);

        // Random traffic with redirects, faults, stalls and wrap-around targets.
        p_ready = 70; p_iready = 60; p_redir = 6; p_err = 3; max_lat = 3;
        run(4000);

        // Settle onto a known path.
        quiet();
        frc_valid = 1'b1; frc_pc = 64'h8000_0100;
        run(8);

        // Misaligned redirect parks the unit in FAULT with no requests.
        frc_valid = 1'b1; frc_pc = 64'h8000_0102;
        run(4);
        chk("mis_fault", fetch_fault, 1'b1);
        chk("mis_noreq", imem_req_valid, 1'b0);

        // An aligned redirect clears the fault and resumes at the target.
        frc_valid = 1'b1; frc_pc = 64'h8000_0200;
        run(1);
        chk("fault_clear", fetch_fault, 1'b0);
        chk("resume_addr", imem_req_addr, 64'h8000_0200);
        chk("resume_valid", imem_req_valid, 1'b1);

        // PC wraps modulo 2^64.
        frc_valid = 1'b1; frc_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        run(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
